// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg
// Shared definitions for the AXI AW arbiter slice:
//   - AW sideband field widths (len, size, burst, lock, cache, prot, qos)
//   - arbiter FSM state enumeration
package axi_arb_pkg;

  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int LOCK_W  = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int QOS_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_order_fifo.sv
// arb_order_fifo
// Small synchronous FIFO that records the index of each granted AW requester
// so the W channel can be routed in grant order.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push, din       : write request and data (ignored when full)
//   pop             : read request (ignored when empty)
//   dout            : oldest entry (undefined content when empty)
//   full, empty     : occupancy flags
module arb_order_fifo
  import axi_arb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; readers qualify it with empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axi_aw_arbiter.sv
// axi_aw_arbiter
// Round-robin arbiter merging NUM_REQ AXI write-address channels onto one
// downstream AW master port. One address is in flight at a time (IDLE/BUSY),
// giving a peak rate of one address every two cycles.
// Optional build macro: AXI_AW_ARB_ORDER_FIFO_EN
//   defined   : grant-order FIFO present; grants stall while it is full and
//               ord_valid/ord_idx present the oldest granted index.
//   undefined : no FIFO, no stall; ord_valid/ord_idx tied 0, ord_pop ignored.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   s_awvalid / s_awready    : per-requester handshake (NUM_REQ bits)
//   s_aw*                    : per-requester fields, flattened NUM_REQ x width
//   m_awvalid / m_awready    : downstream handshake
//   m_aw*                    : registered copy of the winning requester fields
//   ord_valid, ord_idx, ord_pop : grant-order stream for W-channel routing
module axi_aw_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ID_MAX_WIDTH = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int ORD_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            s_awvalid,
  output logic [NUM_REQ-1:0]            s_awready,
  input  logic [NUM_REQ*ID_MAX_WIDTH-1:0] s_awid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_awaddr,
  input  logic [NUM_REQ*LEN_W-1:0]      s_awlen,
  input  logic [NUM_REQ*SIZE_W-1:0]     s_awsize,
  input  logic [NUM_REQ*BURST_W-1:0]    s_awbrust,
  input  logic [NUM_REQ*LOCK_W-1:0]     s_awlock,
  input  logic [NUM_REQ*CACHE_W-1:0]    s_awcache,
  input  logic [NUM_REQ*PROT_W-1:0]     s_awprot,
  input  logic [NUM_REQ*QOS_W-1:0]      s_awqos,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [ID_MAX_WIDTH-1:0]       m_awid,
  output logic [ADDR_WIDTH-1:0]         m_awaddr,
  output logic [LEN_W-1:0]              m_awlen,
  output logic [SIZE_W-1:0]             m_awsize,
  output logic [BURST_W-1:0]            m_awbrust,
  output logic [LOCK_W-1:0]             m_awlock,
  output logic [CACHE_W-1:0]            m_awcache,
  output logic [PROT_W-1:0]             m_awprot,
  output logic [QOS_W-1:0]              m_awqos,
  output logic                          ord_valid,
  output logic [$clog2(NUM_REQ)-1:0]    ord_idx,
  input  logic                          ord_pop
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // First asserted request at or after ptr, wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic             found;
    int               cand_i;
    logic [IDX_W-1:0] cand;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_i = (int'(ptr) + k) % NUM_REQ;
      cand   = IDX_W'(cand_i);
      if (!found && req[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

  arb_state_e state;
  arb_state_e state_next;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win_p0;
  logic [IDX_W-1:0] win_p1;
  logic             grant_p0;
  logic             fifo_full;

  logic [ID_MAX_WIDTH-1:0] sel_id;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [LEN_W-1:0]        sel_len;
  logic [SIZE_W-1:0]       sel_size;
  logic [BURST_W-1:0]      sel_burst;
  logic [LOCK_W-1:0]       sel_lock;
  logic [CACHE_W-1:0]      sel_cache;
  logic [PROT_W-1:0]       sel_prot;
  logic [QOS_W-1:0]        sel_qos;

  // ---- stage p0: arbitration and field selection (combinational) ----
  always_comb begin
    state_next = state;
    grant_p0   = 1'b0;
    s_awready  = '0;
    win_p0     = rr_pick(s_awvalid, rr_ptr);
    case (state)
      IDLE: begin
        // rst gating keeps s_awready low throughout reset.
        if (!rst && (|s_awvalid) && !fifo_full) begin
          grant_p0          = 1'b1;
          s_awready[win_p0] = 1'b1;
          state_next        = BUSY;
        end
      end
      BUSY: begin
        if (m_awready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel_id    = '0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    sel_lock  = '0;
    sel_cache = '0;
    sel_prot  = '0;
    sel_qos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_p0 == IDX_W'(i)) begin
        sel_id    = s_awid[i*ID_MAX_WIDTH +: ID_MAX_WIDTH];
        sel_addr  = s_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len   = s_awlen[i*LEN_W +: LEN_W];
        sel_size  = s_awsize[i*SIZE_W +: SIZE_W];
        sel_burst = s_awbrust[i*BURST_W +: BURST_W];
        sel_lock  = s_awlock[i*LOCK_W +: LOCK_W];
        sel_cache = s_awcache[i*CACHE_W +: CACHE_W];
        sel_prot  = s_awprot[i*PROT_W +: PROT_W];
        sel_qos   = s_awqos[i*QOS_W +: QOS_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---- stage p1: registered downstream AW beat ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      win_p1    <= '0;
      m_awvalid <= 1'b0;
      m_awid    <= '0;
      m_awaddr  <= '0;
      m_awlen   <= '0;
      m_awsize  <= '0;
      m_awbrust <= '0;
      m_awlock  <= '0;
      m_awcache <= '0;
      m_awprot  <= '0;
      m_awqos   <= '0;
    end else if (grant_p0) begin
      win_p1    <= win_p0;
      m_awvalid <= 1'b1;
      m_awid    <= sel_id;
      m_awaddr  <= sel_addr;
      m_awlen   <= sel_len;
      m_awsize  <= sel_size;
      m_awbrust <= sel_burst;
      m_awlock  <= sel_lock;
      m_awcache <= sel_cache;
      m_awprot  <= sel_prot;
      m_awqos   <= sel_qos;
    end else if (state == BUSY && m_awready) begin
      m_awvalid <= 1'b0;
      rr_ptr    <= (win_p1 == IDX_W'(NUM_REQ-1)) ? '0 : win_p1 + 1'b1;
    end
  end

`ifdef AXI_AW_ARB_ORDER_FIFO_EN
  logic [IDX_W-1:0] fifo_dout;
  logic             fifo_empty;

  arb_order_fifo #(
    .DEPTH (ORD_DEPTH),
    .WIDTH (IDX_W)
  ) u_ord_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant_p0),
    .din   (win_p0),
    .pop   (ord_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Stale storage is hidden so ord_idx reads 0 whenever the FIFO is empty.
  assign ord_valid = ~fifo_empty;
  assign ord_idx   = fifo_empty ? '0 : fifo_dout;
`else
  logic unused_ord_pop;

  assign fifo_full      = 1'b0;
  assign ord_valid      = 1'b0;
  assign ord_idx        = '0;
  assign unused_ord_pop = ord_pop;
`endif

endmodule

// File: tb/tb_axi_aw_arbiter.sv
module tb_axi_aw_arbiter;

  localparam int N     = 4;
  localparam int IDW   = 4;
  localparam int AW    = 32;
  localparam int DEPTH = 8;
`ifdef AXI_AW_ARB_ORDER_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      s_awvalid = '0;
  logic [N-1:0]      s_awready;
  logic [N*IDW-1:0]  s_awid = '0;
  logic [N*AW-1:0]   s_awaddr = '0;
  logic [N*4-1:0]    s_awlen = '0;
  logic [N*3-1:0]    s_awsize = '0;
  logic [N*2-1:0]    s_awbrust = '0;
  logic [N*2-1:0]    s_awlock = '0;
  logic [N*4-1:0]    s_awcache = '0;
  logic [N*3-1:0]    s_awprot = '0;
  logic [N*4-1:0]    s_awqos = '0;
  logic              m_awvalid;
  logic              m_awready = 1'b0;
  logic [IDW-1:0]    m_awid;
  logic [AW-1:0]     m_awaddr;
  logic [3:0]        m_awlen;
  logic [2:0]        m_awsize;
  logic [1:0]        m_awbrust;
  logic [1:0]        m_awlock;
  logic [3:0]        m_awcache;
  logic [2:0]        m_awprot;
  logic [3:0]        m_awqos;
  logic              ord_valid;
  logic [1:0]        ord_idx;
  logic              ord_pop = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  axi_aw_arbiter dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awbrust(s_awbrust), .s_awlock(s_awlock), .s_awcache(s_awcache),
    .s_awprot(s_awprot), .s_awqos(s_awqos),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awbrust(m_awbrust), .m_awlock(m_awlock), .m_awcache(m_awcache),
    .m_awprot(m_awprot), .m_awqos(m_awqos),
    .ord_valid(ord_valid), .ord_idx(ord_idx), .ord_pop(ord_pop)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          mdl_busy;
  int          mdl_ptr;
  int          mdl_win;
  int          ordq[$];
  bit          grant_now;
  int          g_win;
  logic [N-1:0] exp_ready;
  logic [IDW-1:0] exp_id;
  logic [AW-1:0]  exp_addr;
  logic [21:0]    exp_side;

  task automatic model_pre();
    exp_ready = '0;
    grant_now = 1'b0;
    g_win     = 0;
    if (!rst && !mdl_busy && (|s_awvalid) && !(FIFO_EN && ordq.size() >= DEPTH)) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (mdl_ptr + k) % N;
        if (!grant_now && s_awvalid[c]) begin
          g_win     = c;
          grant_now = 1'b1;
        end
      end
      exp_ready[g_win] = 1'b1;
    end
  endtask

  task automatic model_post();
    if (rst) begin
      mdl_busy = 1'b0; mdl_ptr = 0; mdl_win = 0;
      exp_id = '0; exp_addr = '0; exp_side = '0;
      ordq.delete();
    end else begin
      if (mdl_busy && m_awready) begin
        mdl_busy = 1'b0;
        mdl_ptr  = (mdl_win + 1) % N;
      end
      if (FIFO_EN && ord_pop && ordq.size() > 0) void'(ordq.pop_front());
      if (grant_now) begin
        mdl_busy = 1'b1;
        mdl_win  = g_win;
        exp_id   = s_awid[g_win*IDW +: IDW];
        exp_addr = s_awaddr[g_win*AW +: AW];
        exp_side = {s_awlen[g_win*4 +: 4], s_awsize[g_win*3 +: 3], s_awbrust[g_win*2 +: 2],
                    s_awlock[g_win*2 +: 2], s_awcache[g_win*4 +: 4], s_awprot[g_win*3 +: 3],
                    s_awqos[g_win*4 +: 4]};
        if (FIFO_EN) ordq.push_back(g_win);
      end
    end
  endtask

  function automatic logic [1:0] exp_ord_idx();
    return (ordq.size() > 0) ? 2'(ordq[0]) : 2'd0;
  endfunction

  task automatic rand_fields();
    s_awid    = 16'($urandom);
    s_awaddr  = {$urandom, $urandom, $urandom, $urandom};
    s_awlen   = 16'($urandom);
    s_awsize  = 12'($urandom);
    s_awbrust = 8'($urandom);
    s_awlock  = 8'($urandom);
    s_awcache = 16'($urandom);
    s_awprot  = 12'($urandom);
    s_awqos   = 16'($urandom);
  endtask

  // Inputs are changed after the falling edge; model_pre runs once they settle.
  task automatic begin_cycle();
    @(negedge clk);
  endtask
  task automatic settle();
    #1;
    model_pre();
  endtask
  task automatic end_cycle();
    @(posedge clk);
    model_post();
    #1;
  endtask

  task automatic do_reset();
    begin_cycle();
    rst = 1'b1; s_awvalid = '0; m_awready = 1'b0; ord_pop = 1'b0;
    settle(); end_cycle();
    begin_cycle();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      begin_cycle();
      rst = 1'b1; s_awvalid = '1; m_awready = 1'b1;
      settle();
      compared++;
      if (s_awready !== 4'b0000) begin
        mismatched++; $display("FAIL reset_awready: got %b want 0000", s_awready);
      end
      end_cycle();
    end
    compared++;
    if ({m_awvalid, m_awaddr, m_awid, ord_valid, ord_idx} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: vld=%b addr=%h id=%h ov=%b oi=%0d want all 0",
               m_awvalid, m_awaddr, m_awid, ord_valid, ord_idx);
    end
    begin_cycle();
    rst = 1'b0; s_awvalid = '0;
  endtask

  task automatic test_single();
    do_reset();
    rand_fields();
    s_awaddr[2*AW +: AW] = 32'h0000_1000;
    s_awvalid = 4'b0100; m_awready = 1'b1; ord_pop = 1'b0;
    settle();
    compared++;
    if (s_awready !== 4'b0100) begin
      mismatched++; $display("FAIL single_awready: got %b want 0100", s_awready);
    end
    end_cycle();
    compared++;
    if (m_awvalid !== 1'b1 || m_awaddr !== 32'h0000_1000) begin
      mismatched++; $display("FAIL single_out: vld=%b addr=%h want 1 00001000", m_awvalid, m_awaddr);
    end
    compared++;
    if (ord_idx !== (FIFO_EN ? 2'd2 : 2'd0) || ord_valid !== FIFO_EN) begin
      mismatched++; $display("FAIL single_ord: valid=%b idx=%0d want %b %0d",
                             ord_valid, ord_idx, FIFO_EN, FIFO_EN ? 2 : 0);
    end
    begin_cycle();
    s_awvalid = '0; ord_pop = 1'b1;
    settle(); end_cycle();
    compared++;
    if (m_awvalid !== 1'b0 || ord_valid !== 1'b0) begin
      mismatched++; $display("FAIL single_done: vld=%b ov=%b want 0 0", m_awvalid, ord_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    s_awvalid = '1; m_awready = 1'b1; ord_pop = 1'b1;
    for (int c = 0; c < 10; c++) begin
      logic [N-1:0] want;
      if (c > 0) begin_cycle();
      rand_fields();
      settle();
      want = (c % 2 == 0) ? 4'(1 << ((c / 2) % 4)) : 4'b0000;
      compared++;
      if (s_awready !== want) begin
        mismatched++; $display("FAIL rr_cycle%0d: got %b want %b", c, s_awready, want);
      end
      end_cycle();
      compared++;
      if (m_awvalid !== mdl_busy || m_awaddr !== exp_addr || m_awid !== exp_id) begin
        mismatched++; $display("FAIL rr_out%0d: vld=%b addr=%h id=%h want %b %h %h",
                               c, m_awvalid, m_awaddr, m_awid, mdl_busy, exp_addr, exp_id);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] held;
    do_reset();
    rand_fields();
    s_awvalid = 4'b0010; m_awready = 1'b0; ord_pop = 1'b1;
    settle();
    compared++;
    if (s_awready !== 4'b0010) begin
      mismatched++; $display("FAIL bp_grant: got %b want 0010", s_awready);
    end
    held = s_awaddr[1*AW +: AW];
    end_cycle();
    for (int c = 0; c < 5; c++) begin
      begin_cycle();
      rand_fields(); s_awvalid = '1;
      settle();
      compared++;
      if (s_awready !== 4'b0000) begin
        mismatched++; $display("FAIL bp_ready%0d: got %b want 0000", c, s_awready);
      end
      end_cycle();
      compared++;
      if (m_awvalid !== 1'b1 || m_awaddr !== held) begin
        mismatched++; $display("FAIL bp_hold%0d: vld=%b addr=%h want 1 %h", c, m_awvalid, m_awaddr, held);
      end
    end
    begin_cycle();
    m_awready = 1'b1;
    settle(); end_cycle();
    compared++;
    if (m_awvalid !== 1'b0) begin
      mismatched++; $display("FAIL bp_release: vld=%b want 0", m_awvalid);
    end
    begin_cycle();
    settle();
    compared++;
    if (s_awready !== 4'b0100) begin
      mismatched++; $display("FAIL bp_next: got %b want 0100", s_awready);
    end
    end_cycle();
  endtask

  task automatic test_fifo_full();
    int grants = 0;
    do_reset();
    s_awvalid = '1; m_awready = 1'b1; ord_pop = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin_cycle();
      settle();
      if (s_awready !== 4'b0000) grants++;
      end_cycle();
    end
    compared++;
    if (grants !== (FIFO_EN ? 8 : 10)) begin
      mismatched++; $display("FAIL full_grants: got %0d want %0d", grants, FIFO_EN ? 8 : 10);
    end
    begin_cycle();
    ord_pop = 1'b1;
    settle();
    compared++;
    if (s_awready !== (FIFO_EN ? 4'b0000 : 4'b0100)) begin
      mismatched++; $display("FAIL full_pop_cycle: got %b want %b", s_awready, FIFO_EN ? 4'b0000 : 4'b0100);
    end
    end_cycle();
    begin_cycle();
    ord_pop = 1'b0;
    settle();
    compared++;
    if (s_awready !== (FIFO_EN ? 4'b0001 : 4'b0000)) begin
      mismatched++; $display("FAIL full_after_pop: got %b want %b", s_awready, FIFO_EN ? 4'b0001 : 4'b0000);
    end
    end_cycle();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    rand_fields();
    s_awvalid = 4'b1100; m_awready = 1'b0; ord_pop = 1'b0;
    settle();
    compared++;
    if (s_awready !== 4'b0100) begin
      mismatched++; $display("FAIL mid_grant: got %b want 0100", s_awready);
    end
    end_cycle();
    begin_cycle();
    rst = 1'b1;
    settle(); end_cycle();
    compared++;
    if (m_awvalid !== 1'b0 || ord_valid !== 1'b0 || m_awaddr !== '0) begin
      mismatched++; $display("FAIL mid_reset: vld=%b ov=%b addr=%h want 0 0 0", m_awvalid, ord_valid, m_awaddr);
    end
    begin_cycle();
    rst = 1'b0; s_awvalid = 4'b1010;
    settle();
    compared++;
    if (s_awready !== 4'b0010) begin
      mismatched++; $display("FAIL mid_first: got %b want 0010", s_awready);
    end
    end_cycle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c > 0) begin_cycle();
      rst       = ($urandom_range(0, 59) == 0);
      s_awvalid = 4'($urandom);
      m_awready = ($urandom_range(0, 9) < 7);
      ord_pop   = ($urandom_range(0, 9) < 3);
      rand_fields();
      settle();
      compared++;
      if (s_awready !== exp_ready) begin
        mismatched++; $display("FAIL rnd_ready%0d: got %b want %b", c, s_awready, exp_ready);
      end
      end_cycle();
      compared++;
      if (m_awvalid !== mdl_busy || m_awid !== exp_id || m_awaddr !== exp_addr ||
          {m_awlen, m_awsize, m_awbrust, m_awlock, m_awcache, m_awprot, m_awqos} !== exp_side) begin
        mismatched++;
        $display("FAIL rnd_out%0d: vld=%b id=%h addr=%h side=%h want %b %h %h %h", c, m_awvalid,
                 m_awid, m_awaddr, {m_awlen, m_awsize, m_awbrust, m_awlock, m_awcache, m_awprot, m_awqos},
                 mdl_busy, exp_id, exp_addr, exp_side);
      end
      compared++;
      if (ord_valid !== (ordq.size() > 0) || ord_idx !== exp_ord_idx()) begin
        mismatched++; $display("FAIL rnd_ord%0d: valid=%b idx=%0d want %b %0d", c, ord_valid, ord_idx,
                               ordq.size() > 0, exp_ord_idx());
      end
    end
    begin_cycle();
    rst = 1'b0;
  endtask

  initial begin
    mdl_busy = 1'b0; mdl_ptr = 0; mdl_win = 0;
    exp_id = '0; exp_addr = '0; exp_side = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_fifo_full();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axi_aw_arbiter.md
AXI_AW_ARBITER -- requirements
Module: axi_aw_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of upstream AW requesters (2..8).
REQ-002 SHALL have parameter ID_MAX_WIDTH, default 4, awid width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, awaddr width.
REQ-004 SHALL have parameter ORD_DEPTH, default 8, grant-order FIFO depth (power of 2).
REQ-005 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have ports s_awvalid/s_awready  in/out  NUM_REQ  per-requester handshake.
REQ-008 SHALL have per-requester flattened inputs, each NUM_REQ x field width: s_awid, s_awaddr, s_awlen(4), s_awsize(3), s_awbrust(2), s_awlock(2), s_awcache(4), s_awprot(3), s_awqos(4).
REQ-009 SHALL have downstream AW master outputs m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awbrust, m_awlock, m_awcache, m_awprot, m_awqos, plus input m_awready.
REQ-010 SHALL have ports ord_valid out 1, ord_idx out clog2(NUM_REQ), ord_pop in 1: grant-order stream for W-channel routing.

Function
REQ-011 SHALL use a two-state FSM: IDLE and BUSY.
REQ-012 In IDLE, when any s_awvalid is high and the order FIFO is not full, SHALL select the first asserted requester at or after rr_ptr (wrapping), call it win.
REQ-013 SHALL assert s_awready[win] combinationally in that cycle only; all other s_awready bits SHALL be 0.
REQ-014 On that cycle's clock edge, SHALL register win's fields into m_aw*, set m_awvalid=1, push win into the order FIFO and enter BUSY. Latency is 1 cycle from s_awvalid to m_awvalid.
REQ-015 In BUSY, s_awready SHALL be all-zero and m_aw* SHALL be held stable until m_awready=1.
REQ-016 On m_awvalid and m_awready, SHALL clear m_awvalid, set rr_ptr=(win+1) mod NUM_REQ and return to IDLE. Peak throughput is 1 address per 2 cycles.
REQ-017 If the order FIFO is full in IDLE, SHALL grant nothing, even if ord_pop is high the same cycle.
REQ-018 ord_valid SHALL be 1 when the FIFO is non-empty, and ord_idx SHALL show the oldest entry. ord_pop with ord_valid=0 SHALL be ignored.
REQ-019 Simultaneous push and pop on a non-full, non-empty FIFO SHALL keep the count unchanged.
REQ-020 Requester fields SHALL pass through unmodified; the block SHALL perform no ID remapping.

Reset
REQ-021 On rst: state=IDLE, rr_ptr=0, m_awvalid=0, all m_aw* fields=0, order FIFO empty (ord_valid=0, ord_idx=0). s_awready SHALL read 0 while rst is high.
REQ-022 rst asserted in BUSY SHALL drop m_awvalid the next cycle with no handshake, and SHALL discard the FIFO contents.

Configuration
REQ-023 Macro AXI_AW_ARB_ORDER_FIFO_EN SHALL control the order FIFO.
REQ-024 With the macro defined, the order FIFO and ord_* ports SHALL behave per REQ-010/017/018/019.
REQ-025 Without the macro, the FIFO SHALL be absent, REQ-017 stalling SHALL not apply, ord_valid SHALL be tied 0, ord_idx tied 0, and ord_pop ignored.

Structure
REQ-026 Package axi_arb_pkg SHALL hold the AW field width constants (LEN_W=4, SIZE_W=3, BURST_W=2, LOCK_W=2, CACHE_W=4, PROT_W=3, QOS_W=4) and the FSM state enum (IDLE, BUSY).
REQ-027 The order FIFO SHALL be the sub-module arb_order_fifo (parameters DEPTH and WIDTH; ports push, din, pop, dout, full, empty).

Verification
REQ-028 Single request: s_awvalid=4'b0100, awaddr=0x1000, m_awready=1 -> s_awready=4'b0100 in cycle 0; m_awvalid=1 with m_awaddr=0x1000 in cycle 1; ord_idx=2.
REQ-029 Round-robin: all 4 requesters valid continuously, m_awready=1 -> grant order 0,1,2,3,0; one grant every 2 cycles.
REQ-030 Backpressure: m_awready=0 for 5 cycles in BUSY -> m_aw* stable, s_awready=0 throughout; grant completes on the cycle m_awready=1.
REQ-031 FIFO full (macro on, ORD_DEPTH=8, ord_pop=0): after 8 grants, s_awready stays 0; one ord_pop -> 9th grant on the next IDLE cycle.
REQ-032 Reset mid-burst: rst=1 while BUSY -> next cycle m_awvalid=0, rr_ptr=0, ord_valid=0; first post-reset grant goes to the lowest asserted index.
REQ-033 Macro off: same stimulus as REQ-029 -> identical grants, ord_valid always 0, no stall.
